// File: rtl/glitch_sequencer_if.sv
// Signal bundle between the host-side config/trigger logic and the glitch sequencer.
// The master drives arm, abort, trigger and the config inputs; the slave is the sequencer.
interface glitch_sequencer_if #(
    parameter int CNT_W = 16,
    parameter int REP_W = 8
);
    logic             arm;
    logic             abort;
    logic             trigger;
    logic [CNT_W-1:0] cfg_delay;
    logic [CNT_W-1:0] cfg_width;
    logic [CNT_W-1:0] cfg_gap;
    logic [REP_W-1:0] cfg_count;
    logic [3:0]       cfg_mode;

    logic             glitch_en;
    logic [3:0]       glitch_mode;
    logic             armed;
    logic             busy;
    logic             done;
    logic [REP_W-1:0] pulse_idx;

    modport master (
        output arm, abort, trigger, cfg_delay, cfg_width, cfg_gap, cfg_count, cfg_mode,
        input  glitch_en, glitch_mode, armed, busy, done, pulse_idx
    );

    modport slave (
        input  arm, abort, trigger, cfg_delay, cfg_width, cfg_gap, cfg_count, cfg_mode,
        output glitch_en, glitch_mode, armed, busy, done, pulse_idx
    );
endinterface

// File: rtl/glitch_sequencer.sv
// Armed, trigger-started pulse-train generator that is the sole source of the
// glitch core enable; every output comes straight from a flop.
module glitch_sequencer #(
    parameter int CNT_W = 16,
    parameter int REP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    glitch_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        PULSE,
        GAP,
        DONE
    } state_t;

    state_t           state;
    logic [2:0]       sync_q;
    logic             edge_q;
    logic             trig_edge;

    logic [CNT_W-1:0] delay_q;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] gap_q;
    logic [REP_W-1:0] count_q;
    logic [CNT_W-1:0] cnt_q;

    logic             en_q;
    logic [3:0]       mode_q;
    logic             armed_q;
    logic             busy_q;
    logic             done_q;
    logic [REP_W-1:0] idx_q;

    // Three synchronizing stages ahead of the edge flop: a rising trigger first
    // sampled at edge N shows up as trig_edge in the cycle after edge N+2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value and the chain shifts one stage per clock.
            sync_q <= {sync_q[1:0], bus.trigger};
            edge_q <= sync_q[2];
        end
    end

    assign trig_edge = sync_q[2] & ~edge_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            delay_q <= '0;
            width_q <= '0;
            gap_q   <= '0;
            count_q <= '0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            mode_q  <= '0;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else if (bus.abort) begin
            // Abort beats arm and trig_edge; done is not pulsed and pulse_idx holds.
            state   <= IDLE;
            en_q    <= 1'b0;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.arm) begin
                        delay_q <= bus.cfg_delay;
                        width_q <= (bus.cfg_width == '0) ? CNT_W'(1) : bus.cfg_width;
                        gap_q   <= (bus.cfg_gap   == '0) ? CNT_W'(1) : bus.cfg_gap;
                        count_q <= (bus.cfg_count == '0) ? REP_W'(1) : bus.cfg_count;
                        mode_q  <= bus.cfg_mode;
                        idx_q   <= '0;
                        armed_q <= 1'b1;
                        state   <= ARMED;
                    end
                end
                ARMED: begin
                    if (trig_edge) begin
                        armed_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (delay_q != '0) begin
                            cnt_q <= delay_q;
                            state <= DELAY;
                        end else begin
                            cnt_q <= width_q;
                            en_q  <= 1'b1;
                            state <= PULSE;
                        end
                    end
                end
                DELAY: begin
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_q <= width_q;
                        en_q  <= 1'b1;
                        state <= PULSE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                PULSE: begin
                    if (cnt_q == CNT_W'(1)) begin
                        en_q <= 1'b0;
                        if (idx_q == count_q - REP_W'(1)) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            cnt_q <= gap_q;
                            state <= GAP;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == CNT_W'(1)) begin
                        idx_q <= idx_q + REP_W'(1);
                        cnt_q <= width_q;
                        en_q  <= 1'b1;
                        state <= PULSE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.glitch_en   = en_q;
    assign bus.glitch_mode = mode_q;
    assign bus.armed       = armed_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pulse_idx   = idx_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: cycle-exact pulse-train timing, config
// substitution, trigger filtering, abort priority and asynchronous reset.
module tb_glitch_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    glitch_sequencer_if #(.CNT_W(16), .REP_W(8)) bus ();

    glitch_sequencer #(.CNT_W(16), .REP_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        bus.trigger = 1'b0;
        repeat (5) tick();
    endtask

    task automatic do_arm(input logic [15:0] d, input logic [15:0] w, input logic [15:0] g,
                          input logic [7:0] c, input logic [3:0] m);
        bus.cfg_delay = d;
        bus.cfg_width = w;
        bus.cfg_gap   = g;
        bus.cfg_count = c;
        bus.cfg_mode  = m;
        bus.arm       = 1'b1;
        tick();
        bus.arm       = 1'b0;
    endtask

    task automatic test_reset();
        bus.arm = 1'b0; bus.abort = 1'b0; bus.trigger = 1'b0;
        bus.cfg_delay = '0; bus.cfg_width = '0; bus.cfg_gap = '0;
        bus.cfg_count = '0; bus.cfg_mode = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_vec++;
        if ({bus.glitch_en, bus.glitch_mode, bus.armed, bus.busy, bus.done, bus.pulse_idx} !== 16'h0) begin
            n_err++;
            $display("FAIL reset_outputs got en=%b mode=%b armed=%b busy=%b done=%b idx=%0d want all 0",
                     bus.glitch_en, bus.glitch_mode, bus.armed, bus.busy, bus.done, bus.pulse_idx);
        end
    endtask

    // delay=4 width=2 gap=3 count=3: pulses at N+7..8, N+12..13, N+17..18, done at N+19.
    task automatic test_train();
        logic       exp_en, exp_done, exp_busy, exp_armed;
        logic [7:0] exp_idx;
        do_arm(16'd4, 16'd2, 16'd3, 8'd3, 4'b0100);
        bus.trigger = 1'b1;
        tick();
        for (int k = 1; k <= 22; k++) begin
            tick();
            exp_en    = (k == 7 || k == 8 || k == 12 || k == 13 || k == 17 || k == 18);
            exp_done  = (k == 19);
            exp_busy  = (k >= 3 && k <= 18);
            exp_armed = (k <= 2);
            exp_idx   = (k < 12) ? 8'd0 : (k < 17) ? 8'd1 : 8'd2;
            n_vec++;
            if ({bus.glitch_en, bus.done, bus.busy, bus.armed, bus.pulse_idx, bus.glitch_mode} !==
                {exp_en, exp_done, exp_busy, exp_armed, exp_idx, 4'b0100}) begin
                n_err++;
                $display("FAIL train k=%0d got en=%b done=%b busy=%b armed=%b idx=%0d mode=%b want en=%b done=%b busy=%b armed=%b idx=%0d mode=0100",
                         k, bus.glitch_en, bus.done, bus.busy, bus.armed, bus.pulse_idx, bus.glitch_mode,
                         exp_en, exp_done, exp_busy, exp_armed, exp_idx);
            end
        end
        settle();
    endtask

    // All-zero config: one single-cycle pulse at N+3, done at N+4.
    task automatic test_zero_cfg();
        do_arm(16'd0, 16'd0, 16'd0, 8'd0, 4'b1111);
        bus.trigger = 1'b1;
        tick();
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_vec++;
            if ({bus.glitch_en, bus.done, bus.busy, bus.pulse_idx} !== {(k == 3), (k == 4), (k == 3), 8'd0}) begin
                n_err++;
                $display("FAIL zero_cfg k=%0d got en=%b done=%b busy=%b idx=%0d want en=%b done=%b busy=%b idx=0",
                         k, bus.glitch_en, bus.done, bus.busy, bus.pulse_idx, (k == 3), (k == 4), (k == 3));
            end
        end
        settle();
    endtask

    // delay=1 width=5 gap=1 count=3; abort lands on the 2nd cycle of the 2nd pulse.
    task automatic test_abort();
        logic exp_en;
        do_arm(16'd1, 16'd5, 16'd1, 8'd3, 4'b0001);
        bus.trigger = 1'b1;
        tick();
        for (int k = 1; k <= 11; k++) begin
            tick();
            exp_en = (k >= 4 && k <= 8) || (k >= 10);
            n_vec++;
            if (bus.glitch_en !== exp_en) begin
                n_err++;
                $display("FAIL abort_pre k=%0d got en=%b want %b", k, bus.glitch_en, exp_en);
            end
        end
        bus.abort = 1'b1;
        tick();
        bus.abort   = 1'b0;
        bus.trigger = 1'b0;
        n_vec++;
        if ({bus.glitch_en, bus.busy, bus.armed, bus.done, bus.pulse_idx} !== {4'b0000, 8'd1}) begin
            n_err++;
            $display("FAIL abort_edge got en=%b busy=%b armed=%b done=%b idx=%0d want 0 0 0 0 1",
                     bus.glitch_en, bus.busy, bus.armed, bus.done, bus.pulse_idx);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            n_vec++;
            if ({bus.glitch_en, bus.busy, bus.armed, bus.done, bus.pulse_idx} !== {4'b0000, 8'd1}) begin
                n_err++;
                $display("FAIL abort_after k=%0d got en=%b busy=%b armed=%b done=%b idx=%0d want 0 0 0 0 1",
                         k, bus.glitch_en, bus.busy, bus.armed, bus.done, bus.pulse_idx);
            end
        end
    endtask

    // Trigger edges in IDLE do nothing; a re-trigger during DELAY does not restart it.
    task automatic test_trigger_filter();
        bus.trigger = 1'b1; repeat (3) tick();
        bus.trigger = 1'b0; repeat (2) tick();
        bus.trigger = 1'b1; repeat (2) tick();
        bus.trigger = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_vec++;
            if ({bus.glitch_en, bus.armed, bus.busy} !== 3'b000) begin
                n_err++;
                $display("FAIL idle_trigger k=%0d got en=%b armed=%b busy=%b want 000",
                         k, bus.glitch_en, bus.armed, bus.busy);
            end
        end
        do_arm(16'd4, 16'd1, 16'd1, 8'd1, 4'b0010);
        bus.trigger = 1'b1;
        tick();
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_vec++;
            if ({bus.glitch_en, bus.done, bus.busy} !== {(k == 7), (k == 8), (k >= 3 && k <= 7)}) begin
                n_err++;
                $display("FAIL delay_retrigger k=%0d got en=%b done=%b busy=%b want en=%b done=%b busy=%b",
                         k, bus.glitch_en, bus.done, bus.busy, (k == 7), (k == 8), (k >= 3 && k <= 7));
            end
            if (k == 1) bus.trigger = 1'b0;
            if (k == 2) bus.trigger = 1'b1;
        end
        settle();
    endtask

    // arm+abort in IDLE stays IDLE; config changes and re-arm while ARMED are ignored.
    task automatic test_arm_rules();
        bus.arm   = 1'b1;
        bus.abort = 1'b1;
        bus.cfg_mode = 4'b0111;
        tick();
        bus.arm   = 1'b0;
        bus.abort = 1'b0;
        n_vec++;
        if ({bus.armed, bus.busy} !== 2'b00) begin
            n_err++;
            $display("FAIL arm_abort_idle got armed=%b busy=%b want 00", bus.armed, bus.busy);
        end
        do_arm(16'd3, 16'd2, 16'd2, 8'd1, 4'b1010);
        n_vec++;
        if ({bus.armed, bus.glitch_mode} !== 5'b1_1010) begin
            n_err++;
            $display("FAIL arm_latch got armed=%b mode=%b want 1 1010", bus.armed, bus.glitch_mode);
        end
        do_arm(16'd9, 16'd7, 16'd7, 8'd4, 4'b0011);
        n_vec++;
        if ({bus.armed, bus.glitch_mode} !== 5'b1_1010) begin
            n_err++;
            $display("FAIL rearm_ignored got armed=%b mode=%b want 1 1010", bus.armed, bus.glitch_mode);
        end
        bus.trigger = 1'b1;
        tick();
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_vec++;
            if ({bus.glitch_en, bus.done, bus.glitch_mode} !== {(k == 6 || k == 7), (k == 8), 4'b1010}) begin
                n_err++;
                $display("FAIL latched_cfg k=%0d got en=%b done=%b mode=%b want en=%b done=%b mode=1010",
                         k, bus.glitch_en, bus.done, bus.glitch_mode, (k == 6 || k == 7), (k == 8));
            end
        end
        settle();
    endtask

    // Reset asserted mid-pulse clears outputs without a clock edge.
    task automatic test_async_reset();
        do_arm(16'd0, 16'd20, 16'd1, 8'd1, 4'b0110);
        bus.trigger = 1'b1;
        tick();
        repeat (3) tick();
        n_vec++;
        if (bus.glitch_en !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_pulse got en=%b want 1", bus.glitch_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.glitch_en, bus.glitch_mode, bus.armed, bus.busy, bus.done, bus.pulse_idx} !== 16'h0) begin
            n_err++;
            $display("FAIL async_reset got en=%b mode=%b armed=%b busy=%b done=%b idx=%0d want all 0",
                     bus.glitch_en, bus.glitch_mode, bus.armed, bus.busy, bus.done, bus.pulse_idx);
        end
        bus.trigger = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        n_vec++;
        if ({bus.glitch_en, bus.armed, bus.busy, bus.done} !== 4'b0000) begin
            n_err++;
            $display("FAIL post_reset_idle got en=%b armed=%b busy=%b done=%b want 0000",
                     bus.glitch_en, bus.armed, bus.busy, bus.done);
        end
        do_arm(16'd0, 16'd1, 16'd1, 8'd1, 4'b0101);
        n_vec++;
        if ({bus.armed, bus.glitch_mode} !== 5'b1_0101) begin
            n_err++;
            $display("FAIL post_reset_arm got armed=%b mode=%b want 1 0101", bus.armed, bus.glitch_mode);
        end
    endtask

    initial begin
        test_reset();
        test_train();
        test_zero_cfg();
        test_abort();
        test_trigger_filter();
        test_arm_rules();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
